// File: rtl/data_memory_lsu.sv
// Byte-addressable data RAM with a valid/ready request port and an in-order response port.
// Word-crossing accesses are split into two beats; the read pipeline depth is configurable.
module data_memory_lsu #(
  parameter int unsigned SIZE             = 4096,
  parameter int unsigned RD_LATENCY       = 1,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned NumWords = SIZE / 4;
  localparam int unsigned WordAw   = $clog2(SIZE) - 2;

  typedef enum logic {StIdle, StSecond} state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [63:0] data;
  } beat_t;

  state_e state_q, state_d;

  logic [31:0] mem [NumWords];

  // Request decode
  logic [1:0]        req_off;
  logic [WordAw-1:0] req_word, req_word_nxt;
  logic [3:0]        size_mask;
  logic [2:0]        req_nbytes;
  logic              req_span, req_err, req_split, accept;
  logic [7:0]        be_span;
  logic [63:0]       wdata_span;
  logic              unused_addr;

  assign req_off      = req_addr[1:0];
  assign req_word     = req_addr[WordAw+1:2];
  assign req_word_nxt = req_word + WordAw'(1);
  assign unused_addr  = ^req_addr[31:WordAw+2];

  always_comb begin
    size_mask  = 4'b1111;
    req_nbytes = 3'd4;
    case (req_size)
      2'd0: begin
        size_mask  = 4'b0001;
        req_nbytes = 3'd1;
      end
      2'd1: begin
        size_mask  = 4'b0011;
        req_nbytes = 3'd2;
      end
      default: ;
    endcase
  end

  assign req_span   = ({1'b0, req_off} + req_nbytes) > 3'd4;
  assign req_err    = (req_size == 2'd3) || (req_span && !ALLOW_MISALIGNED);
  assign req_split  = req_span && !req_err;
  // Lane-align enables and data across a two-word window; the upper half feeds beat 2.
  assign be_span    = {4'b0000, size_mask} << req_off;
  assign wdata_span = {32'h0, req_wdata} << {req_off, 3'b000};

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept && req_split) state_d = StSecond;
      StSecond: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Beat-2 context captured at the accept edge of a split access
  logic [WordAw-1:0] hold_word_q;
  logic [31:0]       hold_wdata_q, hold_lo_q;
  logic [3:0]        hold_be_q;
  logic              hold_we_q, hold_uns_q;
  logic [1:0]        hold_size_q, hold_off_q;

  logic              mem_we;
  logic [WordAw-1:0] mem_waddr, rd_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_word;
    mem_wdata = wdata_span[31:0];
    mem_be    = be_span[3:0];
    rd_addr   = req_word;
    if (state_q == StSecond) begin
      mem_we    = hold_we_q;
      mem_waddr = hold_word_q;
      mem_wdata = hold_wdata_q;
      mem_be    = hold_be_q;
      rd_addr   = hold_word_q;
    end else if (accept && req_we && !req_err) begin
      mem_we = 1'b1;
    end
  end

  assign mem_rdata = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_word_q  <= '0;
      hold_wdata_q <= '0;
      hold_lo_q    <= '0;
      hold_be_q    <= '0;
      hold_we_q    <= 1'b0;
      hold_uns_q   <= 1'b0;
      hold_size_q  <= '0;
      hold_off_q   <= '0;
    end else if (state_q == StIdle && accept && req_split) begin
      hold_word_q  <= req_word_nxt;
      hold_wdata_q <= wdata_span[63:32];
      hold_lo_q    <= mem_rdata;
      hold_be_q    <= be_span[7:4];
      hold_we_q    <= req_we;
      hold_uns_q   <= req_unsigned;
      hold_size_q  <= req_size;
      hold_off_q   <= req_off;
    end
  end

  // Split accesses enter the pipeline at the SECOND edge, one cycle after acceptance
  beat_t push;

  always_comb begin
    push = '0;
    if (state_q == StSecond) begin
      push.valid = 1'b1;
      push.we    = hold_we_q;
      push.size  = hold_size_q;
      push.uns   = hold_uns_q;
      push.off   = hold_off_q;
      push.data  = {mem_rdata, hold_lo_q};
    end else if (accept && !req_split) begin
      push.valid = 1'b1;
      push.err   = req_err;
      push.we    = req_we;
      push.size  = req_size;
      push.uns   = req_unsigned;
      push.off   = req_off;
      push.data  = {32'h0, mem_rdata};
    end
  end

  beat_t pipe_q [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push;
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  beat_t       rsp_beat;
  logic [31:0] merged, extended;

  assign rsp_beat = pipe_q[RD_LATENCY-1];
  assign merged   = rsp_beat.data[{rsp_beat.off, 3'b000} +: 32];

  always_comb begin
    extended = merged;
    case (rsp_beat.size)
      2'd0: extended = rsp_beat.uns ? {24'h0, merged[7:0]} : {{24{merged[7]}}, merged[7:0]};
      2'd1: extended = rsp_beat.uns ? {16'h0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: ;
    endcase
  end

  assign rsp_valid = rsp_beat.valid;
  assign rsp_err   = rsp_beat.valid && rsp_beat.err;
  assign rsp_rdata = (rsp_beat.valid && !rsp_beat.err && !rsp_beat.we) ? extended : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: a split-capable RD_LATENCY=1 instance and a strict RD_LATENCY=3
// instance share one request stream; a byte-level model feeds per-instance response queues.
module tb_data_memory_lsu;

  localparam int unsigned SIZE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        rdy0, rv0, re0, rdy1, rv1, re1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  data_memory_lsu #(.SIZE(SIZE), .RD_LATENCY(1), .ALLOW_MISALIGNED(1'b1)) dut_split (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  data_memory_lsu #(.SIZE(SIZE), .RD_LATENCY(3), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mm0 [SIZE];
  logic [7:0]  mm1 [SIZE];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Byte-level reference: k=0 splits word-crossing accesses, k=1 flags them as errors
  task automatic model(input int k, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output exp_t e, output logic split);
    int nb, off, a, lat, idx;
    logic span, err;
    logic [31:0] v;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    a     = int'(addr % SIZE);
    lat   = (k == 0) ? 1 : 3;
    span  = (off + nb) > 4;
    err   = (size == 2'd3) || (span && k == 1);
    split = span && !err;
    v     = 32'h0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        idx = (a + i) % SIZE;
        if (we) begin
          if (k == 0) mm0[idx] = wdata[8*i +: 8];
          else        mm1[idx] = wdata[8*i +: 8];
        end else begin
          v[8*i +: 8] = (k == 0) ? mm0[idx] : mm1[idx];
        end
      end
    end
    if (size == 2'd0)      v = uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    else if (size == 2'd1) v = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    e.rdata = (err || we) ? 32'h0 : v;
    e.err   = err;
    e.due   = cyc + lat + (split ? 1 : 0);
  endtask

  // Called at a negedge; returns at the negedge where the next request may be driven
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e0, e1;
    logic s0, s1;
    chk("ready_before_send", 32'({rdy0, rdy1}), 32'h3);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    model(0, we, size, uns, addr, wdata, e0, s0);
    q0.push_back(e0);
    model(1, we, size, uns, addr, wdata, e1, s1);
    q1.push_back(e1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (s0) begin
      chk("split_stall_ready", 32'(rdy0), 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic check_rsp(input int k, input exp_t e, input logic [31:0] d, input logic er);
    chk($sformatf("rsp%0d_cycle", k), 32'(cyc), 32'(e.due));
    chk($sformatf("rsp%0d_rdata", k), d, e.rdata);
    chk($sformatf("rsp%0d_err", k), 32'(er), 32'(e.err));
  endtask

  always @(negedge clk) begin
    if (rv0) begin
      n_tests++;
      assert (q0.size() > 0) else begin
        n_fail++;
        $error("FAIL rsp0_unexpected: got rdata %h err %b expected no response", rd0, re0);
      end
      if (q0.size() > 0) check_rsp(0, q0.pop_front(), rd0, re0);
    end else if (q0.size() > 0 && q0[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $error("FAIL rsp0_missing: got none expected response at cycle %0d", q0[0].due);
      void'(q0.pop_front());
    end
    if (rv1) begin
      n_tests++;
      assert (q1.size() > 0) else begin
        n_fail++;
        $error("FAIL rsp1_unexpected: got rdata %h err %b expected no response", rd1, re1);
      end
      if (q1.size() > 0) check_rsp(1, q1.pop_front(), rd1, re1);
    end else if (q1.size() > 0 && q1[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $error("FAIL rsp1_missing: got none expected response at cycle %0d", q1[0].due);
      void'(q1.pop_front());
    end
  end

  task automatic drain();
    for (int i = 0; i < 12 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    chk("drain_q0_empty", 32'(q0.size()), 32'h0);
    chk("drain_q1_empty", 32'(q1.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'({rdy0, rdy1}), 32'h3);
    chk("reset_rsp_valid", 32'({rv0, rv1}), 32'h0);
    chk("reset_rsp_err", 32'({re0, re1}), 32'h0);
    chk("reset_rdata0", rd0, 32'h0);
    chk("reset_rdata1", rd1, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Preload, then store/load with a load immediately after the store
    send(1'b1, 2'd2, 1'b0, 32'h00, 32'h01020304);
    send(1'b1, 2'd2, 1'b0, 32'h04, 32'h05060708);
    send(1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFEF00D);
    send(1'b1, 2'd2, 1'b0, 32'h0C, 32'hA5A5A5A5);
    send(1'b1, 2'd2, 1'b0, 32'h14, 32'h55667788);
    send(1'b1, 2'd2, 1'b0, SIZE - 4, 32'h0BADCAFE);
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Byte store with junk upper data, signed and unsigned loads
    send(1'b1, 2'd0, 1'b0, 32'h21, 32'h12345680);
    send(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    send(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);

    // Word-crossing store and loads
    send(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344);
    send(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
    send(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
    send(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0);
    send(1'b0, 2'd1, 1'b0, 32'h0D, 32'h0);

    // Misaligned store at 0x03 then word read of 0x00; illegal size
    send(1'b1, 2'd2, 1'b0, 32'h03, 32'hAABBCCDD);
    send(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    send(1'b1, 2'd3, 1'b0, 32'h14, 32'hFFFFFFFF);
    send(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);

    // Back-to-back aligned loads
    send(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);

    // Wrap from the last word to word 0, and high address bits ignored
    send(1'b1, 2'd2, 1'b0, SIZE - 2, 32'h99887766);
    send(1'b0, 2'd2, 1'b1, SIZE - 2, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0);
    drain();

    // Reset while the split instance is in its second beat; no response may follow
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h201;
    req_wdata = 32'h13572468;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midop_reset_ready", 32'({rdy0, rdy1}), 32'h3);
    chk("midop_reset_rsp_valid", 32'({rv0, rv1}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_ready", 32'({rdy0, rdy1}), 32'h3);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    send(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
